depacketizer_n: RTL and testbench

DEPACKETIZER_N -- requirements
Module: depacketizer_n

---
 rtl/depacketizer_pkg.sv | 16 +
 rtl/depkt_flit_decode.sv | 33 +++
 rtl/depacketizer_n.sv | 154 +++++++++++++++
 tb/tb_depacketizer_n.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/depacketizer_pkg.sv
// rtl/depacketizer_pkg.sv - shared flit flag offsets and FSM state type
// Purpose: flag bit positions, measured down from the flit MSB
//          (bit = WIDTH_FLIT - *_OFS), and the depacketizer FSM state enum.
// Ports:   none (package).
package depacketizer_pkg;

  localparam int VALID_OFS = 1;
  localparam int HEAD_OFS  = 2;
  localparam int TAIL_OFS  = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/depkt_flit_decode.sv
// rtl/depkt_flit_decode.sv - combinational field extraction of one flit
// Purpose: splits a flit into valid/head/tail flags, VC field and payload.
// Ports:   flit         - raw flit
//          flag_valid   - flit valid bit
//          flag_head    - head flit marker
//          flag_tail    - tail flit marker
//          vc           - virtual-channel field
//          payload_body - body/tail payload (everything below the VC field)
//          payload_head - head payload (below the destination field)
module depkt_flit_decode
  import depacketizer_pkg::*;
#(
  parameter int WIDTH_FLIT       = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic [WIDTH_FLIT-1:0]                                flit,
  output logic                                                 flag_valid,
  output logic                                                 flag_head,
  output logic                                                 flag_tail,
  output logic [VC_ADDRESS_WIDTH-1:0]                          vc,
  output logic [WIDTH_FLIT-4-VC_ADDRESS_WIDTH:0]               payload_body,
  output logic [WIDTH_FLIT-4-VC_ADDRESS_WIDTH-ADDRESS_WIDTH:0] payload_head
);

  assign flag_valid   = flit[WIDTH_FLIT-VALID_OFS];
  assign flag_head    = flit[WIDTH_FLIT-HEAD_OFS];
  assign flag_tail    = flit[WIDTH_FLIT-TAIL_OFS];
  assign vc           = flit[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];
  assign payload_body = flit[WIDTH_FLIT-4-VC_ADDRESS_WIDTH:0];
  assign payload_head = flit[WIDTH_FLIT-4-VC_ADDRESS_WIDTH-ADDRESS_WIDTH:0];

endmodule

// File: rtl/depacketizer_n.sv
// rtl/depacketizer_n.sv - reassembles a head/body/tail flit stream into one payload word
// Purpose: collects up to NUM_FLITS flits, places each payload MSB-first in
//          arrival order and presents the top WIDTH_DATA bits with a
//          valid/ready handshake (one-cycle latency, no bubble on back-to-back).
// Ports:   clk, rst_n (async active-low)
//          flit_in, valid_in, ready_out    - upstream flit stream
//          data_out, vc_out, valid_out,
//          ready_in                         - downstream packet stream
//          err_count                        - saturating error-event count,
//                                             only with DEPKT_ERR_CNT_EN defined
// Macro:   DEPKT_ERR_CNT_EN
module depacketizer_n
  import depacketizer_pkg::*;
#(
  parameter int WIDTH_FLIT       = 36,
  parameter int NUM_FLITS        = 4,
  parameter int WIDTH_DATA       = 100,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_FLIT-1:0]       flit_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in
`ifdef DEPKT_ERR_CNT_EN
  ,
  output logic [7:0]                  err_count
`endif
);

  localparam int PB   = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
  localparam int PH   = PB - ADDRESS_WIDTH;
  localparam int FULL = NUM_FLITS * PB - ADDRESS_WIDTH;
  localparam logic [3:0] LAST = 4'(NUM_FLITS - 1);

  if (WIDTH_DATA > FULL) begin : g_width_check
    $error("depacketizer_n: WIDTH_DATA exceeds the reassembled payload width");
  end

  logic                        f_valid, f_head, f_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [PB-1:0]               f_pl_body;
  logic [PH-1:0]               f_pl_head;

  depkt_flit_decode #(
    .WIDTH_FLIT       (WIDTH_FLIT),
    .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
    .ADDRESS_WIDTH    (ADDRESS_WIDTH)
  ) u_decode (
    .flit         (flit_in),
    .flag_valid   (f_valid),
    .flag_head    (f_head),
    .flag_tail    (f_tail),
    .vc           (f_vc),
    .payload_body (f_pl_body),
    .payload_head (f_pl_head)
  );

  state_t                      state, state_next;
  logic [3:0]                  count;
  logic [FULL-1:0]             acc, acc_next;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic                        accept, head_done;
  logic                        load_head, load_body, complete;

  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out && f_valid;
  // A lone head closes the packet when tagged tail or when packets are one flit long.
  assign head_done = f_tail || (NUM_FLITS == 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      if (f_head)
        state_next = head_done ? ST_IDLE : ST_COLLECT;
      else if (state == ST_COLLECT && (f_tail || count == LAST))
        state_next = ST_IDLE;
    end
  end

  // A head is always taken (restarting any partial packet); a body/tail seen
  // in IDLE loads nothing and is simply dropped.
  always_comb begin
    load_head = 1'b0;
    load_body = 1'b0;
    complete  = 1'b0;
    if (accept) begin
      if (f_head) begin
        load_head = 1'b1;
        complete  = head_done;
      end else if (state == ST_COLLECT) begin
        load_body = 1'b1;
        complete  = f_tail || (count == LAST);
      end
    end
  end

  // Flit k (k >= 1) sits (NUM_FLITS-1-k) body slots above bit 0; the head
  // fills the top PH bits and clears the slots of any stale packet.
  always_comb begin
    acc_next = acc;
    if (load_head)
      acc_next = FULL'(f_pl_head) << (FULL - PH);
    else if (load_body)
      acc_next = acc | (FULL'(f_pl_body) << ((int'(LAST) - int'(count)) * PB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= '0;
      vc_q      <= '0;
      data_out  <= '0;
      vc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      acc <= acc_next;
      if (load_head) begin
        count <= 4'd1;
        vc_q  <= f_vc;
      end else if (load_body) begin
        count <= count + 4'd1;
      end
      if (complete) begin
        data_out  <= acc_next[FULL-1 -: WIDTH_DATA];
        vc_out    <= load_head ? f_vc : vc_q;
        valid_out <= 1'b1;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef DEPKT_ERR_CNT_EN
  logic err_evt;
  assign err_evt = accept && (f_head ? (state == ST_COLLECT) : (state == ST_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_count <= '0;
    else if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_depacketizer_n.sv
// tb/tb_depacketizer_n.sv - directed self-checking bench for depacketizer_n
// Purpose: drives hand-built flit sequences and compares delivered packets
//          against hand-computed payloads.
// Ports:   none (top-level bench). Macro: DEPKT_ERR_CNT_EN adds err_count checks.
module tb_depacketizer_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] flit_in;
  logic        valid_in;
  logic        ready_out;
  logic [99:0] data_out;
  logic [0:0]  vc_out;
  logic        valid_out;
  logic        ready_in;
`ifdef DEPKT_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [99:0] q_data[$];
  logic        q_vc[$];

  always #5 clk = ~clk;

  depacketizer_n dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flit_in   (flit_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .vc_out    (vc_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
`ifdef DEPKT_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Record every handshake; inputs only change just after posedge, so the
  // negedge view is the one the next posedge consumes.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      q_data.push_back(data_out);
      q_vc.push_back(vc_out[0]);
    end
  end

  function automatic logic [35:0] mk_head(input logic vc, input logic tail, input logic [27:0] pl);
    return {1'b1, 1'b1, tail, vc, 4'h5, pl};
  endfunction

  function automatic logic [35:0] mk_body(input logic vc, input logic tail, input logic [31:0] pl);
    return {1'b1, 1'b0, tail, vc, pl};
  endfunction

  // Called just after a posedge; returns just after the edge that took the flit.
  task automatic send(input logic [35:0] f);
    int n;
    n = 0;
    flit_in  = f;
    valid_in = 1'b1;
    while (!ready_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready_out got %b want 1", ready_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    flit_in  = '0;
  endtask

  task automatic wait_q(input int want);
    int n;
    n = 0;
    while (q_data.size() < want && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid_in = 1'b0; flit_in = '0; ready_in = 1'b1;
    #12;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    n_cmp++; if (data_out !== 100'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_cmp++; if (vc_out !== 1'b0) begin n_bad++; $display("FAIL reset_vc: got %b want 0", vc_out); end
`ifdef DEPKT_ERR_CNT_EN
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_count); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multi;
    q_data.delete(); q_vc.delete();
    ready_in = 1'b1;
    send(mk_head(1'b1, 1'b0, 28'hABCDEF1));
    send(mk_body(1'b1, 1'b0, 32'h11111111));
    send(mk_body(1'b1, 1'b0, 32'h22222222));
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL multi_early: valid_out got %b want 0", valid_out); end
    send(mk_body(1'b1, 1'b1, 32'h33333333));
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL multi_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 100'hABCDEF1111111112222222233) begin n_bad++; $display("FAIL multi_data: got %h want %h", data_out, 100'hABCDEF1111111112222222233); end
    n_cmp++; if (vc_out !== 1'b1) begin n_bad++; $display("FAIL multi_vc: got %b want 1", vc_out); end
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL multi_pulse: valid_out got %b want 0", valid_out); end
    n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL multi_count: got %0d want 1", q_data.size()); end
  endtask

  task automatic test_single;
    ready_in = 1'b1;
    send(mk_head(1'b0, 1'b1, 28'hFFFFFFF));
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 100'hFFFFFFF000000000000000000) begin n_bad++; $display("FAIL single_data: got %h want %h", data_out, 100'hFFFFFFF000000000000000000); end
    n_cmp++; if (vc_out !== 1'b0) begin n_bad++; $display("FAIL single_vc: got %b want 0", vc_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_max_len;
    ready_in = 1'b1;
    send(mk_head(1'b1, 1'b0, 28'h0000001));
    send(mk_body(1'b1, 1'b0, 32'h44444444));
    send(mk_body(1'b1, 1'b0, 32'h55555555));
    send(mk_body(1'b1, 1'b0, 32'h66666666));
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL maxlen_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 100'h0000001444444445555555566) begin n_bad++; $display("FAIL maxlen_data: got %h want %h", data_out, 100'h0000001444444445555555566); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    q_data.delete(); q_vc.delete();
    ready_in = 1'b1;
    send(mk_head(1'b1, 1'b1, 28'h0F0F0F0));
    send(mk_head(1'b0, 1'b1, 28'h1234ABC));
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", valid_out); end
    n_cmp++; if (data_out !== 100'h1234ABC000000000000000000) begin n_bad++; $display("FAIL b2b_data: got %h want %h", data_out, 100'h1234ABC000000000000000000); end
    @(posedge clk); #1;
    n_cmp++; if (q_data.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", q_data.size()); end
    else begin
      n_cmp++; if (q_data[0] !== 100'h0F0F0F0000000000000000000) begin n_bad++; $display("FAIL b2b_first: got %h want %h", q_data[0], 100'h0F0F0F0000000000000000000); end
      n_cmp++; if (q_vc[0] !== 1'b1 || q_vc[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_vc: got %b%b want 10", q_vc[0], q_vc[1]); end
    end
  endtask

  task automatic test_backpressure;
    q_data.delete(); q_vc.delete();
    ready_in = 1'b0;
    send(mk_head(1'b1, 1'b1, 28'h1234567));
    fork
      begin
        send(mk_head(1'b0, 1'b0, 28'h7654321));
        send(mk_body(1'b0, 1'b1, 32'hCAFEBABE));
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #2;
          n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, ready_out); end
          n_cmp++; if (valid_out !== 1'b1 || data_out !== 100'h1234567000000000000000000) begin n_bad++; $display("FAIL bp_hold[%0d]: valid %b data %h want 1 %h", i, valid_out, data_out, 100'h1234567000000000000000000); end
        end
        ready_in = 1'b1;
      end
    join
    wait_q(2);
    n_cmp++; if (q_data.size() != 2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", q_data.size()); end
    else begin
      n_cmp++; if (q_data[0] !== 100'h1234567000000000000000000) begin n_bad++; $display("FAIL bp_first: got %h want %h", q_data[0], 100'h1234567000000000000000000); end
      n_cmp++; if (q_data[1] !== 100'h7654321CAFEBABE0000000000) begin n_bad++; $display("FAIL bp_second: got %h want %h", q_data[1], 100'h7654321CAFEBABE0000000000); end
    end
  endtask

  task automatic test_restart;
    q_data.delete(); q_vc.delete();
    ready_in = 1'b1;
    send(mk_head(1'b1, 1'b0, 28'h1111111));
    send(mk_body(1'b1, 1'b0, 32'hAAAAAAAA));
    send(mk_head(1'b0, 1'b0, 28'h2222222));
    send(mk_body(1'b0, 1'b1, 32'h55555555));
    wait_q(1);
    @(posedge clk); #1;
    n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL restart_count: got %0d want 1", q_data.size()); end
    else begin
      n_cmp++; if (q_data[0] !== 100'h2222222555555550000000000) begin n_bad++; $display("FAIL restart_data: got %h want %h", q_data[0], 100'h2222222555555550000000000); end
      n_cmp++; if (q_vc[0] !== 1'b0) begin n_bad++; $display("FAIL restart_vc: got %b want 0", q_vc[0]); end
    end
`ifdef DEPKT_ERR_CNT_EN
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL restart_err: got %0d want 1", err_count); end
`endif
  endtask

  task automatic test_reset_mid;
    q_data.delete(); q_vc.delete();
    ready_in = 1'b0;
    send(mk_head(1'b1, 1'b1, 28'h9999999));
    rst_n = 1'b0; #1;
    n_cmp++; if (valid_out !== 1'b0 || data_out !== 100'h0) begin n_bad++; $display("FAIL rmid_clear: valid %b data %h want 0 0", valid_out, data_out); end
    @(posedge clk); #1;
    rst_n = 1'b1; ready_in = 1'b1;
    send(mk_head(1'b1, 1'b0, 28'h3333333));
    send(mk_body(1'b1, 1'b0, 32'h77777777));
    rst_n = 1'b0; #1;
    n_cmp++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin n_bad++; $display("FAIL rmid_reset: valid %b ready %b want 0 1", valid_out, ready_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(mk_body(1'b1, 1'b1, 32'hDEADBEEF));
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_drop: valid_out got %b want 0", valid_out); end
    send(mk_head(1'b1, 1'b0, 28'h0ABCDEF));
    send(mk_body(1'b1, 1'b1, 32'h87654321));
    wait_q(1);
    @(posedge clk); #1;
    n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL rmid_count: got %0d want 1", q_data.size()); end
    else begin
      n_cmp++; if (q_data[0] !== 100'h0ABCDEF876543210000000000) begin n_bad++; $display("FAIL rmid_data: got %h want %h", q_data[0], 100'h0ABCDEF876543210000000000); end
    end
`ifdef DEPKT_ERR_CNT_EN
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL rmid_err: got %0d want 1", err_count); end
`endif
  endtask

  initial begin
    test_reset;
    test_multi;
    test_single;
    test_max_len;
    test_back_to_back;
    test_backpressure;
    test_restart;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
